// File: rtl/subtrator_pkg.sv
// subtrator_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_t   : FSM state encoding (IDLE, SHIFT, DONE)
//   - SUB_WIDTH : default operand/result width
package subtrator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 4;

endpackage

// File: rtl/subtrator_serial_4bits_bit.sv
// subtrator_bit
//   Combinational full-subtractor cell computing one bit of a - b - bin.
//   Ports:
//     a    : minuend bit
//     b    : subtrahend bit
//     bin  : borrow in from the less significant bit
//     d    : difference bit
//     bout : borrow out to the more significant bit
module subtrator_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits match and a borrow
  // is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial_4bits.sv
// subtrator_serial_4bits
//   Bit-serial subtractor: c = a - b (mod 2^WIDTH), one bit per clock,
//   LSB first, with a start/busy/done handshake.
//
//   Handshake: start is sampled only while IDLE; an accepted start latches
//   a and b. busy is high for the WIDTH cycles of SHIFT. done is a one-cycle
//   pulse that marks c/borrow_out/overflow valid; busy and done are never
//   high together. start is ignored while busy or done (not queued).
//   c, borrow_out and overflow hold their value until the next result or rst.
//
//   Optional feature macro: SUB_OVERFLOW_EN
//     defined   -> overflow is the registered signed-overflow flag
//     undefined -> overflow is tied to 0 (port kept)
//
//   Ports:
//     clk_100M   : clock, rising edge
//     rst        : synchronous active-high reset
//     start      : operation request
//     a, b       : minuend / subtrahend (WIDTH bits)
//     c          : difference (WIDTH bits)
//     borrow_out : 1 iff unsigned a < b
//     busy       : high while shifting
//     done       : one-cycle result-valid pulse
//     overflow   : signed overflow flag
//     fsm_state  : current FSM state, for observation
module subtrator_serial_4bits
  import subtrator_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             borrow_out,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output state_t           fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // One cell serves every bit position; the shift registers present the
  // current bit at their LSB.
  subtrator_bit u_bit (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d),
    .bout (br_next)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0
  // has arrived at position 0.
  assign res_next = (res_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign fsm_state = state;

`ifdef SUB_OVERFLOW_EN
  // Operand MSBs are shifted out during SHIFT, so keep copies for the
  // overflow decision at the end.
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      c          <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SUB_OVERFLOW_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            c          <= res_next;
            borrow_out <= br_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
`ifdef SUB_OVERFLOW_EN
            // Signed overflow: operands differ in sign and the result sign
            // disagrees with the minuend.
            overflow   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SUB_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/subtrator_serial_4bits.md
# subtrator_serial_4bits

Bit-serial subtractor that computes `c = a - b` on two WIDTH-bit operands, one bit per `clk_100M` cycle, starting from the LSB. It is the inverse counterpart of the parallel 4-bit adder. It uses a start/busy/done handshake so that arithmetic-unit benches and top-level datapaths can sequence operations on the same 100 MHz clock. Outputs hold the last result until the next accepted start.

## Interface
- `WIDTH`, default 4: operand and result width; the bit counter is `$clog2(WIDTH)` bits wide (minimum 1).
- `clk_100M`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request; sampled only in IDLE.
- `a`, input, WIDTH: minuend; latched on an accepted start.
- `b`, input, WIDTH: subtrahend; latched on an accepted start.
- `c`, output, WIDTH: difference `a - b` mod 2^WIDTH.
- `borrow_out`, output, 1: borrow out of the MSB; equals 1 iff unsigned `a < b`.
- `busy`, output, 1: high while in SHIFT.
- `done`, output, 1: single-cycle pulse when `c` and `borrow_out` become valid.
- `overflow`, output, 1: signed overflow flag; see Configuration.

## Operation
- **Reset state:** FSM is IDLE. `c`=0, `borrow_out`=0, `busy`=0, `done`=0, `overflow`=0, shift registers=0, counter=0.
- **IDLE:**
  - `start`=1 at an edge latches `a` and `b` into shift registers and clears the internal borrow `br` and the counter.
  - The FSM moves to SHIFT.
  - Changes to `a`/`b` after acceptance have no effect.
- **SHIFT:** each edge processes bit `i` (the LSB of each shift register):
  - `d = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - `d` is shifted into the result register at the MSB end, shifting right.
  - Operand registers shift right; the counter increments.
  - When the counter reaches WIDTH-1 on this edge: copy the result to `c` and the final `br'` to `borrow_out`, compute `overflow`, and go to DONE.
- **DONE:** `done`=1 for exactly this one cycle. The next edge returns the FSM to IDLE unconditionally.
- **Ignored starts:** `start` is ignored in SHIFT and DONE; it is neither queued nor latched. `start` must be reasserted in IDLE to be accepted.
- **Output hold:** `c`, `borrow_out` and `overflow` change only on the DONE-entry edge or on reset.
- **Arithmetic:** unsigned modulo 2^WIDTH. `a == b` gives `c`=0 and `borrow_out`=0.

## Timing
- Let edge k accept `start`.
- Edges k+1 .. k+WIDTH process bits 0 .. WIDTH-1.
- `busy`=1 in the cycles following edges k through k+WIDTH-1.
- `done`=1 and outputs are valid after edge k+WIDTH. For WIDTH=4 that is 4 cycles of latency from acceptance.
- IDLE is re-entered after edge k+WIDTH+1.
- The earliest next accept is edge k+WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high simultaneously.
- **Reset mid-operation:** `rst`=1 at any edge overrides everything. The FSM goes to IDLE and all outputs and registers clear on that edge; the in-flight result is discarded and no `done` is issued.
- **`rst` and `start` both high:** reset wins.

## Configuration
- Macro: `SUB_OVERFLOW_EN`.
- **Defined:**
  - `overflow` is registered with the result: `(a_msb != b_msb) && (c_msb != a_msb)`, using the latched operands.
  - It holds until the next result or reset.
- **Undefined:**
  - `overflow` is tied to constant 0.
  - No MSB capture registers are synthesized.
  - The port remains, so the interface is unchanged.

## Structure
- **Package `subtrator_pkg`:**
  - State encoding typedef: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default width constant `SUB_WIDTH` = 4.
- **Sub-module `subtrator_bit`:** a combinational full-subtractor cell (inputs `a`, `b`, `bin`; outputs `d`, `bout`). It is instantiated once and reused every cycle. The top module holds the FSM, counter, shift registers and output registers.

## Test plan
- **Basic subtract:** `a`=0011, `b`=0001, pulse `start` -> `done` 4 cycles later, `c`=0010, `borrow_out`=0, `overflow`=0.
- **Underflow wrap:** `a`=0000, `b`=0001 -> `c`=1111, `borrow_out`=1, `overflow`=0. Likewise `a`=0001, `b`=0111 -> `c`=1010, `borrow_out`=1.
- **Equal operands and signed overflow:**
  - `a`=1111, `b`=1111 -> `c`=0000, `borrow_out`=0.
  - `a`=0111, `b`=1111 -> `c`=1000, `borrow_out`=1, `overflow`=1 with `SUB_OVERFLOW_EN` defined, 0 without.
- **Busy lockout:**
  - Accept `a`=0100, `b`=0011, then hold `start`=1 with `a`=1111, `b`=0000 through SHIFT and DONE.
  - Expect the first result `c`=0001, `borrow_out`=0.
  - The second operation is accepted only in the IDLE cycle after DONE; its `done` arrives 4 cycles later with `c`=1111, `borrow_out`=0.
  - `busy` is never high together with `done`.
- **Reset mid-op:**
  - Accept `a`=0111, `b`=0011 and assert `rst` on the second SHIFT edge -> all outputs 0, no `done` pulse.
  - Then start `a`=0111, `b`=0011 -> `c`=0100, `borrow_out`=0.
- **Operand stability:** change `a` and `b` every cycle during SHIFT -> the result reflects only the values latched at acceptance.
